// File: rtl/selfadd_pkg.sv
// Shared definitions for the self-add heap sequencing controller.
package selfadd_pkg;

  localparam int ADDER_LAT = 3;
  localparam int WORD_W    = 32;
  localparam int HALF_W    = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

endpackage

// File: rtl/selfadd_rr_idx.sv
// Wrapping unit-index / pass counter. Used for round-robin word routing
// during accumulation and for result selection during drain.
module selfadd_rr_idx #(
  parameter int NUM_UNITS = 32,
  parameter int PASSES    = 8,
  parameter int IDX_W     = $clog2(NUM_UNITS),
  parameter int PASS_W    = (PASSES > 1) ? $clog2(PASSES) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              inc,
  output logic [IDX_W-1:0]  idx,
  output logic [PASS_W-1:0] pass_cnt,
  output logic              last_unit,
  output logic              last_pass,
  output logic              wrap
);

  assign last_unit = (idx == IDX_W'(NUM_UNITS - 1));
  assign last_pass = (pass_cnt == PASS_W'(PASSES - 1));
  assign wrap      = inc & last_unit;

  // Advance the unit index; every index wrap bumps the pass count.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      idx      <= '0;
      pass_cnt <= '0;
    end else if (inc) begin
      if (last_unit) begin
        idx      <= '0;
        pass_cnt <= last_pass ? '0 : pass_cnt + PASS_W'(1);
      end else begin
        idx <= idx + IDX_W'(1);
      end
    end
  end

endmodule

// File: rtl/selfadd_heap_ctrl.sv
// Sequencing controller for the self-add register heap.
// Routes input words round-robin into the heap units for PASSES passes
// (clearing each unit on the first pass), waits out the adder pipeline,
// then drains every unit result over a valid/ready port.
// Optional build macro SELFADD_HEAP_CTRL_ABORT_EN adds an abort input and
// a sticky err output.
//
// state | meaning
// IDLE  | waiting for start
// ACCUM | accepting words, one per unit per pass
// FLUSH | letting the last adder results settle
// DRAIN | presenting unit results to the output port
module selfadd_heap_ctrl
  import selfadd_pkg::*;
#(
  parameter int NUM_UNITS = 32,
  parameter int PASSES    = 8,
  parameter int ADDER_LAT = selfadd_pkg::ADDER_LAT,
  parameter int IDX_W     = $clog2(NUM_UNITS)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [WORD_W-1:0]           in_data,
  output logic [NUM_UNITS-1:0]        heap_data_v,
  output logic [NUM_UNITS-1:0]        heap_usr_rst,
  output logic [WORD_W-1:0]           heap_data,
  input  logic [NUM_UNITS*WORD_W-1:0] heap_rd_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [WORD_W-1:0]           out_data,
  output logic                        out_last,
`ifdef SELFADD_HEAP_CTRL_ABORT_EN
  input  logic                        abort,
  output logic                        err,
`endif
  output logic                        busy,
  output logic                        done
);

  localparam int PASS_W  = (PASSES > 1) ? $clog2(PASSES) : 1;
  localparam int FLUSH_W = $clog2(ADDER_LAT + 2) + 1;

  state_e               state, state_nx;
  logic [FLUSH_W-1:0]   flush_cnt;
  logic [IDX_W-1:0]     idx;
  logic [PASS_W-1:0]    pass_cnt;
  logic                 last_unit, last_pass, wrap;
  logic                 accept, hs, start_go, abort_go, flush_done;
  logic                 rr_clr, rr_inc;
  logic [NUM_UNITS-1:0] unit_sel;
  logic [WORD_W-1:0]    rd_word;

  assign in_ready   = (state == ST_ACCUM);
  assign out_valid  = (state == ST_DRAIN);
  assign busy       = (state != ST_IDLE);
  assign accept     = in_valid & in_ready;
  assign hs         = out_valid & out_ready;
  assign start_go   = (state == ST_IDLE) & start;
  assign flush_done = (state == ST_FLUSH) && (flush_cnt == FLUSH_W'(ADDER_LAT + 1));

`ifdef SELFADD_HEAP_CTRL_ABORT_EN
  assign abort_go = abort & ((state == ST_ACCUM) | (state == ST_FLUSH));
`else
  assign abort_go = 1'b0;
`endif

  assign rr_clr   = start_go | flush_done | abort_go;
  assign rr_inc   = accept | hs;
  assign unit_sel = NUM_UNITS'(1) << idx;

  selfadd_rr_idx #(
    .NUM_UNITS (NUM_UNITS),
    .PASSES    (PASSES),
    .IDX_W     (IDX_W),
    .PASS_W    (PASS_W)
  ) u_rr_idx (
    .clk       (clk),
    .rst       (rst),
    .clr       (rr_clr),
    .inc       (rr_inc),
    .idx       (idx),
    .pass_cnt  (pass_cnt),
    .last_unit (last_unit),
    .last_pass (last_pass),
    .wrap      (wrap)
  );

  // Next-state selection; abort overrides every other transition.
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (start) state_nx = ST_ACCUM;
      ST_ACCUM: if (accept && wrap && last_pass) state_nx = ST_FLUSH;
      ST_FLUSH: if (flush_done) state_nx = ST_DRAIN;
      ST_DRAIN: if (hs && last_unit) state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
    if (abort_go) state_nx = ST_IDLE;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  // Flush timer: runs only while in FLUSH, so it starts at zero on entry.
  always_ff @(posedge clk) begin
    if (rst || (state != ST_FLUSH)) flush_cnt <= '0;
    else                            flush_cnt <= flush_cnt + FLUSH_W'(1);
  end

  // Registered heap write strobes; the broadcast word holds between accepts.
  always_ff @(posedge clk) begin
    if (rst) begin
      heap_data_v  <= '0;
      heap_usr_rst <= '0;
      heap_data    <= '0;
    end else begin
      heap_data_v  <= (accept && !abort_go) ? unit_sel : '0;
      heap_usr_rst <= (accept && !abort_go && pass_cnt == '0) ? unit_sel : '0;
      if (accept && !abort_go) heap_data <= in_data;
    end
  end

  // Select the current unit's result from the flattened heap read bus.
  always_comb begin
    rd_word = '0;
    for (int i = 0; i < NUM_UNITS; i++) begin
      if (idx == IDX_W'(i)) rd_word = heap_rd_data[i*WORD_W +: WORD_W];
    end
  end

  assign out_data = out_valid ? rd_word : '0;
  assign out_last = out_valid & last_unit;

  // Completion pulse one cycle after the final drain handshake.
  always_ff @(posedge clk) begin
    if (rst) done <= 1'b0;
    else     done <= hs & last_unit;
  end

`ifdef SELFADD_HEAP_CTRL_ABORT_EN
  // Sticky abort flag, cleared when the next job is started.
  always_ff @(posedge clk) begin
    if (rst)           err <= 1'b0;
    else if (abort_go) err <= 1'b1;
    else if (start_go) err <= 1'b0;
  end
`endif

endmodule

// File: tb/tb_selfadd_heap_ctrl.sv
// Self-checking bench for selfadd_heap_ctrl with a behavioural heap model.
module tb_selfadd_heap_ctrl;

  localparam int NU  = 4;
  localparam int NP  = 2;
  localparam int LAT = 3;
  localparam int NW  = NU * NP;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [31:0]       in_data = '0;
  logic [NU-1:0]     heap_data_v, heap_usr_rst;
  logic [31:0]       heap_data;
  logic [NU*32-1:0]  heap_rd_data;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [31:0]       out_data;
  logic              out_last;
  logic              busy, done;
`ifdef SELFADD_HEAP_CTRL_ABORT_EN
  logic              abort = 1'b0;
  logic              err;
`endif

  int checks = 0;
  int failures = 0;

  selfadd_heap_ctrl #(.NUM_UNITS(NU), .PASSES(NP), .ADDER_LAT(LAT), .IDX_W(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .heap_data_v  (heap_data_v),
    .heap_usr_rst (heap_usr_rst),
    .heap_data    (heap_data),
    .heap_rd_data (heap_rd_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_last     (out_last),
`ifdef SELFADD_HEAP_CTRL_ABORT_EN
    .abort        (abort),
    .err          (err),
`endif
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] lane_add(input logic [31:0] x, input logic [31:0] y);
    logic [15:0] lo, hi;
    lo = x[15:0] + y[15:0];
    hi = x[31:16] + y[31:16];
    return {hi, lo};
  endfunction

  // Heap model: per unit, result = usr_rst ? data : acc + data, visible LAT edges later.
  logic [31:0] acc  [NU] = '{default: 32'hDEAD_BEEF};
  logic        s0_v [NU] = '{default: 1'b0};
  logic        s1_v [NU] = '{default: 1'b0};
  logic        s2_v [NU] = '{default: 1'b0};
  logic [31:0] s0_d [NU] = '{default: 32'h0};
  logic [31:0] s1_d [NU] = '{default: 32'h0};
  logic [31:0] s2_d [NU] = '{default: 32'h0};

  always @(posedge clk) begin
    for (int i = 0; i < NU; i++) begin
      s0_v[i] <= heap_data_v[i];
      s0_d[i] <= heap_usr_rst[i] ? heap_data : lane_add(acc[i], heap_data);
      s1_v[i] <= s0_v[i];
      s1_d[i] <= s0_d[i];
      s2_v[i] <= s1_v[i];
      s2_d[i] <= s1_d[i];
      if (s2_v[i]) acc[i] <= s2_d[i];
    end
  end

  always_comb begin
    heap_rd_data = '0;
    for (int i = 0; i < NU; i++) heap_rd_data[i*32 +: 32] = acc[i];
  end

  typedef struct {
    logic [31:0] in_w;
    logic [31:0] exp_w;
  } vec_t;

  vec_t        tbl [4];
  logic [31:0] job_w [NW];
  logic [31:0] exp_d [NU];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_data"}, out_data, 0);
    chk({tag, "_out_last"}, out_last, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_heap_data_v"}, heap_data_v, 0);
    chk({tag, "_heap_usr_rst"}, heap_usr_rst, 0);
    chk({tag, "_heap_data"}, heap_data, 0);
`ifdef SELFADD_HEAP_CTRL_ABORT_EN
    chk({tag, "_err"}, err, 0);
`endif
  endtask

  task automatic set_uniform(input logic [31:0] w, input logic [31:0] e);
    for (int k = 0; k < NW; k++) job_w[k] = w;
    for (int u = 0; u < NU; u++) exp_d[u] = e;
  endtask

  task automatic model_expect();
    logic [31:0] s;
    for (int u = 0; u < NU; u++) begin
      s = job_w[u];
      for (int p = 1; p < NP; p++) s = lane_add(s, job_w[p*NU + u]);
      exp_d[u] = s;
    end
  endtask

  // Starts a job; entered and left on a negedge.
  task automatic start_job(input bit with_valid);
    @(negedge clk);
    start = 1'b1; in_valid = with_valid; in_data = 32'hBAD0_BAD0;
    @(posedge clk); @(negedge clk);
    start = 1'b0; in_valid = 1'b0;
    chk("busy_after_start", busy, 1);
    chk("in_ready_accum", in_ready, 1);
    chk("no_accept_on_start", heap_data_v, 0);
  endtask

  // gap_mode: 0 none, 1 every other cycle, 2 random.
  task automatic feed(input int n, input int gap_mode, input bit mid_start);
    bit gap;
    for (int k = 0; k < n; k++) begin
      gap = (gap_mode == 1) || (gap_mode == 2 && $urandom_range(0, 1) == 1);
      if (gap) begin
        in_valid = 1'b0;
        start = mid_start && (k == 3);
        @(posedge clk); @(negedge clk);
        start = 1'b0;
        chk("gap_no_strobe", heap_data_v, 0);
      end
      in_valid = 1'b1; in_data = job_w[k];
      chk("in_ready_feed", in_ready, 1);
      @(posedge clk); @(negedge clk);
      chk("heap_data_v", heap_data_v, NU'(1) << (k % NU));
      chk("heap_usr_rst", heap_usr_rst, (k < NU) ? (NU'(1) << (k % NU)) : NU'(0));
      chk("heap_data", heap_data, job_w[k]);
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    chk("in_ready_flush", in_ready, 0);
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("flush_cycles", n, LAT + 2);
  endtask

  // bp_mode: 0 always ready, 1 pattern 1,0,0,1, 2 random.
  task automatic drain(input int bp_mode);
    int  h, cyc;
    bit  r;
    bit  pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    h = 0; cyc = 0;
    while (h < NU && cyc < 200) begin
      chk("drain_valid", out_valid, 1);
      chk("drain_data", out_data, exp_d[h]);
      chk("drain_last", out_last, (h == NU - 1) ? 1 : 0);
      chk("done_early", done, 0);
      r = (bp_mode == 0) ? 1'b1 : (bp_mode == 1) ? pat[cyc % 4] : 1'($urandom_range(0, 1));
      out_ready = r;
      @(posedge clk);
      if (r) h++;
      @(negedge clk);
      cyc++;
    end
    out_ready = 1'b0;
    chk("drain_timeout", (cyc < 200) ? 1 : 0, 1);
    chk("done_pulse", done, 1);
    chk("idle_after_drain", busy, 0);
    chk("no_extra_valid", out_valid, 0);
    @(negedge clk);
    chk("done_one_cycle", done, 0);
  endtask

  task automatic run_job(input int gap_mode, input bit mid_start, input int bp_mode, input bit with_valid);
    start_job(with_valid);
    feed(NW, gap_mode, mid_start);
    wait_drain();
    drain(bp_mode);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{in_w: 32'h0001_0002, exp_w: 32'h0002_0004};
    tbl[1] = '{in_w: 32'h0003_0005, exp_w: 32'h0006_000A};
    tbl[2] = '{in_w: 32'hFFFF_8000, exp_w: 32'hFFFE_0000};
    tbl[3] = '{in_w: 32'h7FFF_0001, exp_w: 32'hFFFE_0002};

    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;

    // Back-to-back table jobs; the first also drives in_valid with start.
    for (int i = 0; i < 4; i++) begin
      set_uniform(tbl[i].in_w, tbl[i].exp_w);
      run_job(0, 1'b0, 0, i == 0);
    end

    // Output backpressure.
    set_uniform(32'h0001_0002, 32'h0002_0004);
    run_job(0, 1'b0, 1, 1'b0);

    // Input gaps with a start pulse in the middle of accumulation.
    set_uniform(32'h0001_0002, 32'h0002_0004);
    run_job(1, 1'b1, 0, 1'b0);

    // Reset during FLUSH, then a clean job.
    set_uniform(32'h0001_0002, 32'h0002_0004);
    start_job(1'b0);
    feed(NW, 0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    chk_all_zero("rst_flush");
    rst = 1'b0;
    set_uniform(32'h0003_0005, 32'h0006_000A);
    run_job(0, 1'b0, 0, 1'b0);

    // Randomized jobs against the arithmetic model.
    for (int j = 0; j < 4; j++) begin
      for (int k = 0; k < NW; k++) job_w[k] = $urandom;
      model_expect();
      run_job(2, 1'b0, 2, 1'b0);
    end

`ifdef SELFADD_HEAP_CTRL_ABORT_EN
    begin
      bit seen_done;
      set_uniform(32'h0001_0002, 32'h0002_0004);
      start_job(1'b0);
      feed(3, 0, 1'b0);
      abort = 1'b1; in_valid = 1'b1; in_data = 32'h1111_1111;
      @(posedge clk); @(negedge clk);
      abort = 1'b0; in_valid = 1'b0;
      chk("abort_idle", busy, 0);
      chk("abort_err", err, 1);
      chk("abort_no_strobe", heap_data_v, 0);
      seen_done = 1'b0;
      repeat (10) begin
        @(negedge clk);
        seen_done |= done;
      end
      chk("abort_no_done", seen_done, 0);
      chk("abort_err_sticky", err, 1);
      start_job(1'b0);
      chk("err_cleared", err, 0);
      feed(NW, 0, 1'b0);
      wait_drain();
      drain(0);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
